data_mem_responder: RTL

//  Memory-side responder for the MEM-stage data interface: accepts store requests
//  (mem_wr/mem_w_addr/mem_w_data) and load requests, and owns the data SRAM.

---
 rtl/data_mem_responder_if.sv | 28 ++
 rtl/data_mem_responder.sv | 150 +++++++++++++++
 2 files changed

// File: rtl/data_mem_responder_if.sv
// ---------------------------------------------------------------------------
// data_mem_responder_if
//   Bundles the MEM-stage data-memory signals between the pipeline (master)
//   and the data_mem_responder (slave).
//   Pipeline -> memory : mem_wr, mem_w_addr, mem_w_data, mem_rd, mem_r_addr
//   Memory -> pipeline : mem_r_data, mem_r_valid, mem_stall, wb_empty
// ---------------------------------------------------------------------------
interface data_mem_responder_if;
  logic        mem_wr;
  logic [31:0] mem_w_addr;
  logic [31:0] mem_w_data;
  logic        mem_rd;
  logic [31:0] mem_r_addr;
  logic [31:0] mem_r_data;
  logic        mem_r_valid;
  logic        mem_stall;
  logic        wb_empty;

  modport master (
    output mem_wr, mem_w_addr, mem_w_data, mem_rd, mem_r_addr,
    input  mem_r_data, mem_r_valid, mem_stall, wb_empty
  );

  modport slave (
    input  mem_wr, mem_w_addr, mem_w_data, mem_rd, mem_r_addr,
    output mem_r_data, mem_r_valid, mem_stall, wb_empty
  );
endinterface

// File: rtl/data_mem_responder.sv
// ---------------------------------------------------------------------------
// data_mem_responder
//   Memory-side responder for the MEM-stage data interface. Owns a single-port
//   data SRAM of 2**ADDR_W 32-bit words. Stores are posted into a WB_DEPTH-entry
//   circular write buffer and drained into the SRAM on cycles without a load.
//   Loads complete with a fixed one-cycle latency and are forwarded from the
//   youngest matching write-buffer entry when one exists.
//
//   Ports
//     clk   : clock, all state updates on the rising edge
//     rst_n : asynchronous active-low reset
//     bus   : slave side of data_mem_responder_if
//               mem_wr/mem_w_addr/mem_w_data : store request
//               mem_rd/mem_r_addr            : load request
//               mem_r_data/mem_r_valid       : load response (registered)
//               mem_stall                    : write buffer full
//               wb_empty                     : all stores committed to SRAM
// ---------------------------------------------------------------------------
module data_mem_responder #(
  parameter int ADDR_W   = 10,
  parameter int WB_DEPTH = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  data_mem_responder_if.slave  bus
);

  localparam int              PTR_W     = $clog2(WB_DEPTH);
  localparam int              MEM_WORDS = 1 << ADDR_W;
  localparam logic [PTR_W:0]  PTR_ONE   = {{PTR_W{1'b0}}, 1'b1};
  localparam logic [PTR_W:0]  CNT_FULL  = (PTR_W+1)'(WB_DEPTH);
  localparam logic [PTR_W:0]  CNT_ZERO  = {(PTR_W+1){1'b0}};

  // Write buffer storage; entries are only meaningful between rd and wr pointers
  logic [ADDR_W-1:0] r_wb_idx  [WB_DEPTH];
  logic [31:0]       r_wb_data [WB_DEPTH];

  // Pointers carry an extra wrap bit so full and empty are distinguishable
  logic [PTR_W:0]    r_wr_ptr;
  logic [PTR_W:0]    r_rd_ptr;

  // Data SRAM, deliberately not reset
  logic [31:0]       r_sram [MEM_WORDS];

  logic [31:0]       r_rdata;
  logic              r_rvalid;

  logic [PTR_W:0]    w_count;
  logic              w_full;
  logic              w_empty;
  logic              w_push;
  logic              w_drain;
  logic [ADDR_W-1:0] w_w_idx;
  logic [ADDR_W-1:0] w_r_idx;
  logic [PTR_W-1:0]  w_head;
  logic              w_fwd_hit;
  logic [31:0]       w_fwd_data;
  logic [PTR_W-1:0]  w_slot;
  logic              w_slot_match;
  logic [31:0]       w_load_data;
  logic              w_unused_addr_bits;

  // Byte address bits outside the word index alias silently
  assign w_w_idx = bus.mem_w_addr[ADDR_W+1:2];
  assign w_r_idx = bus.mem_r_addr[ADDR_W+1:2];
  assign w_unused_addr_bits = ^{bus.mem_w_addr[31:ADDR_W+2], bus.mem_w_addr[1:0],
                                bus.mem_r_addr[31:ADDR_W+2], bus.mem_r_addr[1:0]};

  assign w_count = r_wr_ptr - r_rd_ptr;
  assign w_full  = (w_count == CNT_FULL);
  assign w_empty = (w_count == CNT_ZERO);
  assign w_head  = r_rd_ptr[PTR_W-1:0];

  // A stalled store is dropped; the pipeline holds and retries it.
  // A load owns the single SRAM port, so draining waits for a load-free cycle.
  assign w_push  = bus.mem_wr & ~w_full;
  assign w_drain = ~bus.mem_rd & ~w_empty;

  // Youngest-match forwarding: walk entries oldest to youngest so a later hit overrides
  always_comb begin
    w_fwd_hit    = 1'b0;
    w_fwd_data   = 32'h0000_0000;
    w_slot       = {PTR_W{1'b0}};
    w_slot_match = 1'b0;
    for (int i = 0; i < WB_DEPTH; i++) begin
      w_slot       = w_head + PTR_W'(i);
      w_slot_match = ((PTR_W+1)'(i) < w_count) && (r_wb_idx[w_slot] == w_r_idx);
      w_fwd_hit    = w_fwd_hit | w_slot_match;
      w_fwd_data   = w_slot_match ? r_wb_data[w_slot] : w_fwd_data;
    end
  end

  // Load source select: buffered data wins over the SRAM copy
  always_comb begin
    if (w_fwd_hit) begin
      w_load_data = w_fwd_data;
    end else begin
      w_load_data = r_sram[w_r_idx];
    end
  end

  // Write-buffer pointer update; push and drain together leave the count unchanged
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= CNT_ZERO;
      r_rd_ptr <= CNT_ZERO;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + PTR_ONE;
      end
      if (w_drain) begin
        r_rd_ptr <= r_rd_ptr + PTR_ONE;
      end
    end
  end

  // Write-buffer entry capture at the write pointer
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_wb_idx[r_wr_ptr[PTR_W-1:0]]  <= w_w_idx;
      r_wb_data[r_wr_ptr[PTR_W-1:0]] <= bus.mem_w_data;
    end
  end

  // SRAM write port, fed only by the buffer head
  always_ff @(posedge clk) begin
    if (w_drain) begin
      r_sram[r_wb_idx[w_head]] <= r_wb_data[w_head];
    end
  end

  // Load response register; data holds its last value between loads
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rvalid <= 1'b0;
      r_rdata  <= 32'h0000_0000;
    end else begin
      r_rvalid <= bus.mem_rd;
      if (bus.mem_rd) begin
        r_rdata <= w_load_data;
      end
    end
  end

  assign bus.mem_r_data  = r_rdata;
  assign bus.mem_r_valid = r_rvalid;
  assign bus.mem_stall   = w_full;
  assign bus.wb_empty    = w_empty;

endmodule
